// File: rtl/bitstream_lane_collector.sv
// Captures NUM_LANES flag/byte lanes, expands them in lane order into a byte FIFO.
// Optional BITSTREAM_COUNT_EN: saturating count of popped bytes on out_byte_count.
module bitstream_lane_collector #(
  parameter int NUM_LANES       = 2,
  parameter int BITSTREAM_WIDTH = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                                   top_clk,
  input  logic                                   top_reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_last,
  input  logic [NUM_LANES*3-1:0]                 in_flag,
  input  logic [NUM_LANES*5*BITSTREAM_WIDTH-1:0] in_bytes,
  output logic [BITSTREAM_WIDTH-1:0]             out_byte,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_last,
  output logic                                   out_done,
  output logic                                   err_invalid_flag,
  output logic [$clog2(FIFO_DEPTH):0]            fifo_level,
  output logic [COUNT_WIDTH-1:0]                 out_byte_count
);

  localparam int BW = BITSTREAM_WIDTH;
  localparam int LW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] RUN_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_HEAD, S_RUN, S_TAIL, S_FINISH
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_LANES*3-1:0]       flags_q, flags_d;
  logic [NUM_LANES*5*BW-1:0]    bytes_q, bytes_d;
  logic                         last_q, last_d;
  logic [2:0]                   sel_q, sel_d;
  logic [2:0]                   idx_q, idx_d;
  logic [BW-1:0]                run_q, run_d;
  logic                         err_q, err_d;

  logic [BW:0]                  mem_q [FIFO_DEPTH];
  logic [LW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW:0]                  count_q, count_d;

  logic                         found;
  logic [2:0]                   first;
  logic [2:0]                   first_flag, cur_flag;
  logic                         more_after;
  logic [BW-1:0]                cur_b [5];
  logic                         wr_req, wr_ok, wr_en, lane_end, pop, full, done_c;
  logic [BW-1:0]                wr_data;
  logic [BW:0]                  head;

  assign full     = (count_q == (LW+1)'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop      = out_valid && out_ready;
  assign wr_ok    = !full || pop;
  assign wr_en    = wr_req && wr_ok;
  assign head     = mem_q[rd_ptr_q];
  assign out_byte = out_valid ? head[BW-1:0] : '0;
  assign out_last = out_valid ? head[BW] : 1'b0;
  assign in_ready = (state_q == S_IDLE);
  assign out_done = done_c;
  assign err_invalid_flag = err_q;
  assign fifo_level = count_q;

  // Lane selection and lookahead: a byte carries out_last only if no later lane will emit.
  always_comb begin
    found      = 1'b0;
    first      = '0;
    more_after = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!found && flags_q[i*3 +: 3] != 3'd0) begin
        found = 1'b1;
        first = 3'(i);
      end
      if (i > int'(sel_q) && flags_q[i*3 +: 3] != 3'd0 && flags_q[i*3 +: 3] != 3'd4)
        more_after = 1'b1;
    end
    first_flag = flags_q[int'(first)*3 +: 3];
    cur_flag   = flags_q[int'(sel_q)*3 +: 3];
    for (int unsigned k = 0; k < 5; k++)
      cur_b[k] = bytes_q[(int'(sel_q)*5 + k)*BW +: BW];
  end

  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    bytes_d  = bytes_q;
    last_d   = last_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    run_d    = run_q;
    err_d    = err_q;
    wr_req   = 1'b0;
    wr_data  = '0;
    lane_end = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          flags_d = in_flag;
          bytes_d = in_bytes;
          last_d  = in_last;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!found) begin
          state_d = S_FINISH;
        end else if (first_flag == 3'd4) begin
          err_d = 1'b1;
          flags_d[int'(first)*3 +: 3] = '0;
        end else begin
          sel_d   = first;
          idx_d   = '0;
          run_d   = '0;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        wr_req = 1'b1;
        if (cur_flag <= 3'd3) begin
          wr_data  = cur_b[idx_q];
          lane_end = (idx_q == cur_flag - 3'd1);
        end else begin
          wr_data  = cur_b[0];
          lane_end = (cur_flag == 3'd5) && (cur_b[2] == '0);
        end
        if (wr_ok) begin
          if (cur_flag > 3'd3) begin
            state_d = S_RUN;
          end else if (lane_end) begin
            flags_d[int'(sel_q)*3 +: 3] = '0;
            state_d = S_SCAN;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_RUN: begin
        if (run_q < cur_b[2]) begin
          wr_req   = 1'b1;
          wr_data  = cur_b[1];
          lane_end = (cur_flag == 3'd5) && ((run_q + RUN_ONE) == cur_b[2]);
          if (wr_ok) run_d = run_q + RUN_ONE;
        end else if (cur_flag == 3'd5) begin
          flags_d[int'(sel_q)*3 +: 3] = '0;
          state_d = S_SCAN;
        end else begin
          idx_d   = '0;
          state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        wr_req   = 1'b1;
        wr_data  = (idx_q == 3'd0) ? cur_b[3] : cur_b[4];
        lane_end = (cur_flag == 3'd6) || (idx_q == 3'd1);
        if (wr_ok) begin
          if (lane_end) begin
            flags_d[int'(sel_q)*3 +: 3] = '0;
            state_d = S_SCAN;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_FINISH: begin
        if (!last_q) begin
          state_d = S_IDLE;
        end else if (count_q == '0) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge top_clk or posedge top_reset) begin
    if (top_reset) begin
      state_q  <= S_IDLE;
      flags_q  <= '0;
      bytes_q  <= '0;
      last_q   <= 1'b0;
      sel_q    <= '0;
      idx_q    <= '0;
      run_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      bytes_q  <= bytes_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge top_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {last_q && lane_end && !more_after, wr_data};
  end

`ifdef BITSTREAM_COUNT_EN
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if (pop && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end
  always_ff @(posedge top_clk or posedge top_reset) begin
    if (top_reset) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
  assign out_byte_count = cnt_q;
`else
  assign out_byte_count = '0;
`endif

endmodule

// File: tb/tb_bitstream_lane_collector.sv
// Directed bench for bitstream_lane_collector (4 lanes, 8-bit bytes, 16-entry FIFO).
module tb_bitstream_lane_collector;
  localparam int NL = 4;
  localparam int BW = 8;

  logic              top_clk = 1'b0;
  logic              top_reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [NL*3-1:0]   in_flag = '0;
  logic [NL*5*BW-1:0] in_bytes = '0;
  logic [BW-1:0]     out_byte;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              out_done;
  logic              err_invalid_flag;
  logic [4:0]        fifo_level;
  logic [31:0]       out_byte_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  int         done_cnt = 0;

  bitstream_lane_collector #(
    .NUM_LANES(NL), .BITSTREAM_WIDTH(BW), .FIFO_DEPTH(16), .COUNT_WIDTH(32)
  ) dut (
    .top_clk(top_clk), .top_reset(top_reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_flag(in_flag), .in_bytes(in_bytes), .out_byte(out_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_done(out_done),
    .err_invalid_flag(err_invalid_flag), .fifo_level(fifo_level),
    .out_byte_count(out_byte_count)
  );

  always #5 top_clk = ~top_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; sampling 2ns later sees the values seen by the next rising edge.
  always begin
    @(negedge top_clk);
    #2;
    if (!top_reset) begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_byte);
        got_last_q.push_back(out_last);
      end
      if (out_done) done_cnt++;
    end
  end

  task automatic clear_lanes();
    in_flag  = '0;
    in_bytes = '0;
    got_q.delete();
    got_last_q.delete();
    done_cnt = 0;
  endtask

  task automatic set_lane(input int l, input logic [2:0] f, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    in_flag[l*3 +: 3]    = f;
    in_bytes[l*40 +: 40] = {b5, b4, b3, b2, b1};
  endtask

  task automatic capture(input logic last);
    int i = 0;
    @(negedge top_clk);
    while (!in_ready && i < 500) begin
      @(negedge top_clk);
      i++;
    end
    check_val("capture_ready_timeout", 32'(i >= 500), 0);
    in_valid = 1'b1;
    in_last  = last;
    @(negedge top_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (!(in_ready && !out_valid) && i < budget) begin
      @(negedge top_clk);
      i++;
    end
    check_val({tag, "_timeout"}, 32'(i >= budget), 0);
    @(negedge top_clk);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] exp[$]);
    check_val({tag, "_len"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check_val($sformatf("%s_b%0d", tag, i), got_q[i], exp[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 1);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_out_byte"}, out_byte, 0);
    check_val({tag, "_out_last"}, out_last, 0);
    check_val({tag, "_out_done"}, out_done, 0);
    check_val({tag, "_err"}, err_invalid_flag, 0);
    check_val({tag, "_level"}, fifo_level, 0);
    check_val({tag, "_count"}, out_byte_count, 0);
  endtask

  task automatic do_reset();
    @(negedge top_clk);
    top_reset = 1'b1;
    #1;
    check_reset_vals("rst_async");
    @(negedge top_clk);
    top_reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp[$];
    int ff_ok;
    logic [31:0] exp_cnt;

    repeat (2) @(negedge top_clk);
    check_reset_vals("rst_init");
    top_reset = 1'b0;
    out_ready = 1'b1;

    // 1: flag3, latency and back-to-back output
    clear_lanes();
    set_lane(0, 3'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00);
    capture(1'b0);
    @(negedge top_clk);
    check_val("t1_valid_e1", out_valid, 0);
    @(negedge top_clk);
    check_val("t1_valid_e2", out_valid, 1);
    check_val("t1_byte0", out_byte, 8'h11);
    @(negedge top_clk);
    check_val("t1_byte1", out_byte, 8'h22);
    @(negedge top_clk);
    check_val("t1_byte2", out_byte, 8'h33);
    wait_idle("t1", 50);
    exp = '{8'h11, 8'h22, 8'h33};
    check_stream("t1", exp);

    // 2: flag7 run, then flag5 with zero run
    clear_lanes();
    set_lane(0, 3'd7, 8'h40, 8'hFF, 8'h03, 8'h41, 8'h42);
    capture(1'b0);
    wait_idle("t2a", 50);
    exp = '{8'h40, 8'hFF, 8'hFF, 8'hFF, 8'h41, 8'h42};
    check_stream("t2a", exp);
    clear_lanes();
    set_lane(0, 3'd5, 8'h40, 8'hFF, 8'h00, 8'h41, 8'h42);
    capture(1'b0);
    wait_idle("t2b", 50);
    exp = '{8'h40};
    check_stream("t2b", exp);

    // 3: four lanes with a skipped zero lane
    clear_lanes();
    set_lane(0, 3'd1, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h00);
    set_lane(1, 3'd0, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    set_lane(2, 3'd2, 8'hA2, 8'hB2, 8'h00, 8'h00, 8'h00);
    set_lane(3, 3'd6, 8'hC3, 8'h00, 8'h02, 8'hD3, 8'h99);
    capture(1'b0);
    wait_idle("t3", 80);
    exp = '{8'hA0, 8'hA2, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'hD3};
    check_stream("t3", exp);

    // all-zero capture returns to idle after the third edge
    clear_lanes();
    capture(1'b0);
    @(negedge top_clk);
    check_val("zero_ready_e1", in_ready, 0);
    @(negedge top_clk);
    check_val("zero_ready_e2", in_ready, 1);
    check_val("zero_no_bytes", got_q.size(), 0);

    // 4: long run with output stall
    do_reset();
    clear_lanes();
    out_ready = 1'b0;
    set_lane(0, 3'd5, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00);
    capture(1'b0);
    repeat (40) @(negedge top_clk);
    check_val("t4_level_full", fifo_level, 16);
    check_val("t4_head", out_byte, 8'h01);
    check_val("t4_ready_low", in_ready, 0);
    out_ready = 1'b1;
    wait_idle("t4", 600);
    check_val("t4_len", got_q.size(), 256);
    check_val("t4_first", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h01);
    ff_ok = 0;
    for (int i = 1; i < got_q.size(); i++) if (got_q[i] == 8'hFF) ff_ok++;
    check_val("t4_run_bytes", ff_ok, 255);
`ifdef BITSTREAM_COUNT_EN
    exp_cnt = 32'd256;
`else
    exp_cnt = 32'd0;
`endif
    check_val("t4_byte_count", out_byte_count, exp_cnt);

    // 5: invalid flag skipped, sticky error
    clear_lanes();
    set_lane(0, 3'd4, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99);
    set_lane(1, 3'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00);
    capture(1'b0);
    wait_idle("t5", 50);
    exp = '{8'h5A};
    check_stream("t5", exp);
    check_val("t5_err", err_invalid_flag, 1);

    // 6: in_last capture, then empty in_last capture
    clear_lanes();
    set_lane(1, 3'd2, 8'h77, 8'h88, 8'h00, 8'h00, 8'h00);
    capture(1'b1);
    wait_idle("t6", 50);
    exp = '{8'h77, 8'h88};
    check_stream("t6", exp);
    check_val("t6_last0", got_last_q.size() > 0 ? got_last_q[0] : 1'b1, 0);
    check_val("t6_last1", got_last_q.size() > 1 ? got_last_q[1] : 1'b0, 1);
    check_val("t6_done", done_cnt, 1);
    check_val("t6_err_sticky", err_invalid_flag, 1);
    clear_lanes();
    capture(1'b1);
    wait_idle("t6e", 50);
    check_val("t6e_no_bytes", got_q.size(), 0);
    check_val("t6e_done", done_cnt, 1);

    // 7: reset in the middle of a stalled run
    clear_lanes();
    out_ready = 1'b0;
    set_lane(0, 3'd5, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00);
    capture(1'b0);
    repeat (30) @(negedge top_clk);
    check_val("t7_pre_level", fifo_level, 16);
    do_reset();
    out_ready = 1'b1;
    repeat (5) @(negedge top_clk);
    check_val("t7_post_valid", out_valid, 0);
    check_val("t7_post_ready", in_ready, 1);
    check_val("t7_post_level", fifo_level, 0);
    check_val("t7_post_err", err_invalid_flag, 0);
    check_val("t7_no_bytes", got_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
